mem_arbiter: RTL and testbench

- Shares a single-port 16-bit memory between the instruction-fetch port and the load/store port of the control unit.
- Fetch is read-only; load/store can read or write.
- Arbitration is round-robin.
- Each owner sees a one-transaction-at-a-time req/ack handshake. A bus timeout converts a missing memory acknowledge into an error response.

---
 rtl/mem_arb_pkg.sv | 42 ++++
 rtl/mem_arbiter_bus_timeout_counter.sv | 39 +++
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: FSM and owner encodings,
// the default bus timeout, and small helpers used by the arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_t;

   localparam int TIMEOUT_DEFAULT = 255;

   // Width of the wait counter: enough to hold TIMEOUT, never narrower than 1.
   function automatic int count_width(input int limit);
      int w;
      if (limit <= 0) begin
         return 1;
      end
      w = $clog2(limit + 1);
      return (w < 1) ? 1 : w;
   endfunction

   // Round-robin choice: a lone requester wins, a tie goes to whoever did not
   // complete the previous transaction.
   function automatic owner_t pick_owner(input logic   if_req,
                                         input logic   ls_req,
                                         input owner_t last_grant);
      if (if_req && ls_req) begin
         return (last_grant == OWN_IF) ? OWN_LS : OWN_IF;
      end
      if (ls_req) begin
         return OWN_LS;
      end
      return OWN_IF;
   endfunction

endpackage

// File: rtl/mem_arbiter_bus_timeout_counter.sv
// Wait counter for one memory access. Counts cycles while enabled, holds at
// its top value instead of wrapping, and flags the last permitted cycle.
module bus_timeout_counter #(
   parameter int LIMIT = 255,
   parameter int CNT_W = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] count;

   // Count access cycles; clear has priority, saturate at all-ones.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != CNT_MAX)) begin
         count <= count + CNT_W'(1);
      end
   end

   // A zero limit turns the timeout off entirely.
   generate
      if (LIMIT == 0) begin : g_off
         assign expired = 1'b0;
      end else begin : g_on
         localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);
         assign expired = (count == LAST);
      end
   endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the fetch port
// (read-only) and the load/store port. Each port runs one transaction at a
// time; a missing memory acknowledge becomes an error response after TIMEOUT
// cycles. Every output is driven from a register.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_err,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic              ls_ack,
   output logic [DATA_W-1:0] ls_rdata,
   output logic              ls_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = count_width(TIMEOUT);

   state_t state;
   owner_t owner;
   owner_t last_grant;
   owner_t next_owner;
   logic   cnt_clear;
   logic   cnt_enable;
   logic   expired;
   logic   finish;

   assign next_owner = pick_owner(if_req, ls_req, last_grant);

   // The counter only runs while an access is outstanding and restarts from
   // zero every time a new access is granted.
   assign cnt_clear  = (state != ST_ACCESS);
   assign cnt_enable = (state == ST_ACCESS);

   // An acknowledge in the expiry cycle still counts as a normal completion.
   assign finish = mem_ack || expired;

   bus_timeout_counter #(
      .LIMIT (TIMEOUT),
      .CNT_W (CNT_W)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (cnt_clear),
      .enable  (cnt_enable),
      .expired (expired)
   );

   // Arbitration FSM: grant in IDLE, wait for memory in ACCESS, one idle DONE
   // cycle so requesters can drop or change req after seeing their ack.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ST_IDLE;
         owner      <= OWN_IF;
         last_grant <= OWN_LS;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         if_ack     <= 1'b0;
         if_err     <= 1'b0;
         if_rdata   <= '0;
         ls_ack     <= 1'b0;
         ls_err     <= 1'b0;
         ls_rdata   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (if_req || ls_req) begin
                  owner   <= next_owner;
                  mem_req <= 1'b1;
                  state   <= ST_ACCESS;
                  if (next_owner == OWN_IF) begin
                     mem_we    <= 1'b0;
                     mem_addr  <= if_addr;
                     mem_wdata <= '0;
                  end else begin
                     mem_we    <= ls_we;
                     mem_addr  <= ls_addr;
                     mem_wdata <= ls_wdata;
                  end
               end
            end

            ST_ACCESS: begin
               if (finish) begin
                  mem_req    <= 1'b0;
                  last_grant <= owner;
                  state      <= ST_DONE;
                  if (owner == OWN_IF) begin
                     if_ack   <= 1'b1;
                     if_err   <= !mem_ack;
                     if_rdata <= mem_ack ? mem_rdata : '0;
                  end else begin
                     ls_ack   <= 1'b1;
                     ls_err   <= !mem_ack;
                     ls_rdata <= (mem_ack && !mem_we) ? mem_rdata : '0;
                  end
               end
            end

            ST_DONE: begin
               if_ack <= 1'b0;
               if_err <= 1'b0;
               ls_ack <= 1'b0;
               ls_err <= 1'b0;
               state  <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter with a 4-cycle timeout: a table of directed
// per-cycle vectors, hand-written multi-cycle sequences, and a randomized run
// checked against a transaction-schedule reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [15:0] if_addr;
   logic        if_ack;
   logic [15:0] if_rdata;
   logic        if_err;
   logic        ls_req;
   logic        ls_we;
   logic [15:0] ls_addr;
   logic [15:0] ls_wdata;
   logic        ls_ack;
   logic [15:0] ls_rdata;
   logic        ls_err;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_ack;
   logic [15:0] mem_rdata;

   logic [69:0] dut_o;

   int n_vec = 0;
   int n_bad = 0;

   mem_arbiter #(
      .ADDR_W  (16),
      .DATA_W  (16),
      .TIMEOUT (TO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_ack    (if_ack),
      .if_rdata  (if_rdata),
      .if_err    (if_err),
      .ls_req    (ls_req),
      .ls_we     (ls_we),
      .ls_addr   (ls_addr),
      .ls_wdata  (ls_wdata),
      .ls_ack    (ls_ack),
      .ls_rdata  (ls_rdata),
      .ls_err    (ls_err),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   assign dut_o = {mem_req, mem_we, mem_addr, mem_wdata,
                   if_ack, if_err, if_rdata, ls_ack, ls_err, ls_rdata};

   typedef struct {
      logic        rst;
      logic        ifr;
      logic [15:0] ifa;
      logic        lsr;
      logic        lswe;
      logic [15:0] lsa;
      logic [15:0] lswd;
      logic        mack;
      logic [15:0] mrd;
      logic [69:0] exp;
   } vec_t;

   // Expected output bundle in the same field order as dut_o.
   function automatic logic [69:0] po(input int mreq, mwe, maddr, mwd,
                                      ifack, iferr, ifrd, lsack, lserr, lsrd);
      return {1'(mreq), 1'(mwe), 16'(maddr), 16'(mwd),
              1'(ifack), 1'(iferr), 16'(ifrd), 1'(lsack), 1'(lserr), 16'(lsrd)};
   endfunction

   function automatic vec_t mk(input int r, ifr, ifa, lsr, lswe, lsa, lswd, mack, mrd,
                               input logic [69:0] e);
      vec_t v;
      v.rst  = 1'(r);
      v.ifr  = 1'(ifr);
      v.ifa  = 16'(ifa);
      v.lsr  = 1'(lsr);
      v.lswe = 1'(lswe);
      v.lsa  = 16'(lsa);
      v.lswd = 16'(lswd);
      v.mack = 1'(mack);
      v.mrd  = 16'(mrd);
      v.exp  = e;
      return v;
   endfunction

   task automatic apply(input vec_t v);
      rst       = v.rst;
      if_req    = v.ifr;
      if_addr   = v.ifa;
      ls_req    = v.lsr;
      ls_we     = v.lswe;
      ls_addr   = v.lsa;
      ls_wdata  = v.lswd;
      mem_ack   = v.mack;
      mem_rdata = v.mrd;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // ---------------- reference model (transaction schedule) ----------------
   // A granted access starts showing mem_req in cycle g. It completes one
   // cycle after the first mem_ack seen while it is outstanding, or in cycle
   // g+TO if none arrives. The arbiter may grant again using the inputs of
   // the cycle after the completion cycle.
   int          m_cyc;
   int          m_g;
   int          m_free;
   bit          m_busy;
   bit          m_own;
   bit          m_last;
   logic        m_mreq, m_mwe;
   logic [15:0] m_maddr, m_mwd;
   logic        m_ifack, m_iferr, m_lsack, m_lserr;
   logic [15:0] m_ifrd, m_lsrd;

   task automatic model_complete(input bit err);
      m_mreq = 1'b0;
      if (m_own == 1'b0) begin
         m_ifack = 1'b1;
         m_iferr = err;
         m_ifrd  = err ? 16'h0000 : mem_rdata;
      end else begin
         m_lsack = 1'b1;
         m_lserr = err;
         m_lsrd  = (err || m_mwe) ? 16'h0000 : mem_rdata;
      end
      m_last = m_own;
      m_busy = 1'b0;
      m_free = m_cyc + 1;
   endtask

   // Advance the model across one clock edge using the inputs just applied.
   task automatic model_step();
      m_cyc++;
      if (!rst) begin
         m_busy  = 1'b0;
         m_last  = 1'b1;
         m_free  = m_cyc;
         m_mreq  = 1'b0;
         m_mwe   = 1'b0;
         m_maddr = 16'h0000;
         m_mwd   = 16'h0000;
         m_ifack = 1'b0;
         m_iferr = 1'b0;
         m_ifrd  = 16'h0000;
         m_lsack = 1'b0;
         m_lserr = 1'b0;
         m_lsrd  = 16'h0000;
         return;
      end
      m_ifack = 1'b0;
      m_iferr = 1'b0;
      m_lsack = 1'b0;
      m_lserr = 1'b0;
      if (m_busy) begin
         if (mem_ack) begin
            model_complete(1'b0);
         end else if (m_cyc == m_g + TO) begin
            model_complete(1'b1);
         end
      end else if ((m_cyc - 1 >= m_free) && (if_req || ls_req)) begin
         m_own   = (if_req && ls_req) ? !m_last : ls_req;
         m_busy  = 1'b1;
         m_g     = m_cyc;
         m_mreq  = 1'b1;
         m_mwe   = m_own ? ls_we : 1'b0;
         m_maddr = m_own ? ls_addr : if_addr;
         m_mwd   = m_own ? ls_wdata : 16'h0000;
      end
   endtask

   initial begin
      vec_t        tbl[$];
      int          nack;
      logic [3:0]  order;
      bit          seen;
      int          age;
      int          lat;

      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, '0));
      m_cyc = 0;

      // Reset with both requests pending, then IF wins the first tie;
      // fetch with one wait cycle; LS write; LS read timeout; LS read acked
      // in the last permitted cycle; stray mem_ack while idle.
      tbl.push_back(mk(0, 1, 'h0100, 1, 1, 'h8000, 'h1234, 0, 0,      po(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mk(0, 1, 'h0100, 1, 1, 'h8000, 'h1234, 0, 0,      po(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mk(1, 1, 'h0100, 1, 1, 'h8000, 'h1234, 0, 0,      po(1, 0, 'h0100, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mk(1, 1, 'h0100, 1, 1, 'h8000, 'h1234, 0, 0,      po(1, 0, 'h0100, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(mk(1, 1, 'h0100, 1, 1, 'h8000, 'h1234, 1, 'hA5A5, po(0, 0, 'h0100, 0, 1, 0, 'hA5A5, 0, 0, 0)));
      tbl.push_back(mk(1, 0, 'h0100, 1, 1, 'h8000, 'h1234, 0, 0,      po(0, 0, 'h0100, 0, 0, 0, 'hA5A5, 0, 0, 0)));
      tbl.push_back(mk(1, 0, 'h0100, 1, 1, 'h8000, 'h1234, 0, 0,      po(1, 1, 'h8000, 'h1234, 0, 0, 'hA5A5, 0, 0, 0)));
      tbl.push_back(mk(1, 0, 'h0100, 1, 1, 'h8000, 'h1234, 1, 'hFFFF, po(0, 1, 'h8000, 'h1234, 0, 0, 'hA5A5, 1, 0, 0)));
      tbl.push_back(mk(1, 0, 'h0100, 0, 0, 'h0200, 0, 0, 0,           po(0, 1, 'h8000, 'h1234, 0, 0, 'hA5A5, 0, 0, 0)));
      tbl.push_back(mk(1, 0, 'h0100, 1, 0, 'h0200, 0, 0, 0,           po(1, 0, 'h0200, 0, 0, 0, 'hA5A5, 0, 0, 0)));
      for (int k = 0; k < 3; k++) begin
         tbl.push_back(mk(1, 0, 'h0100, 1, 0, 'h0200, 0, 0, 0,        po(1, 0, 'h0200, 0, 0, 0, 'hA5A5, 0, 0, 0)));
      end
      tbl.push_back(mk(1, 0, 'h0100, 1, 0, 'h0200, 0, 0, 0,           po(0, 0, 'h0200, 0, 0, 0, 'hA5A5, 1, 1, 0)));
      tbl.push_back(mk(1, 0, 'h0100, 0, 0, 'h0300, 0, 0, 0,           po(0, 0, 'h0200, 0, 0, 0, 'hA5A5, 0, 0, 0)));
      tbl.push_back(mk(1, 0, 'h0100, 1, 0, 'h0300, 0, 0, 0,           po(1, 0, 'h0300, 0, 0, 0, 'hA5A5, 0, 0, 0)));
      for (int k = 0; k < 3; k++) begin
         tbl.push_back(mk(1, 0, 'h0100, 1, 0, 'h0300, 0, 0, 0,        po(1, 0, 'h0300, 0, 0, 0, 'hA5A5, 0, 0, 0)));
      end
      tbl.push_back(mk(1, 0, 'h0100, 1, 0, 'h0300, 0, 1, 'h0042,      po(0, 0, 'h0300, 0, 0, 0, 'hA5A5, 1, 0, 'h0042)));
      tbl.push_back(mk(1, 0, 'h0100, 0, 0, 'h0300, 0, 1, 'hBEEF,      po(0, 0, 'h0300, 0, 0, 0, 'hA5A5, 0, 0, 'h0042)));
      tbl.push_back(mk(1, 0, 'h0100, 0, 0, 'h0300, 0, 1, 'hBEEF,      po(0, 0, 'h0300, 0, 0, 0, 'hA5A5, 0, 0, 'h0042)));

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i]);
         step();
         check($sformatf("tbl[%0d]", i), dut_o, tbl[i].exp);
      end

      // Both ports hold requests; memory acks at once. Grants must alternate.
      if_req = 1'b1; if_addr = 16'h0100;
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'h8000; ls_wdata = 16'h1234;
      mem_ack = 1'b0; mem_rdata = 16'hC0DE;
      nack = 0;
      order = 4'b0000;
      for (int c = 0; c < 30 && nack < 4; c++) begin
         step();
         if (mem_req && mem_we)
            check("rr ls bus", 70'({mem_addr, mem_wdata}), 70'({16'h8000, 16'h1234}));
         if (mem_req && !mem_we)
            check("rr if bus", 70'({mem_addr, mem_wdata}), 70'({16'h0100, 16'h0000}));
         if (ls_ack)
            check("rr ls resp", 70'({ls_err, ls_rdata}), 70'({1'b0, 16'h0000}));
         if (if_ack)
            check("rr if resp", 70'({if_err, if_rdata}), 70'({1'b0, 16'hC0DE}));
         if (if_ack || ls_ack) begin
            order[nack] = ls_ack;
            nack++;
            if (nack == 4) begin
               if_req = 1'b0;
               ls_req = 1'b0;
            end
         end
         mem_ack = mem_req;
      end
      check("rr ack count", 70'(nack), 70'(4));
      check("rr order", 70'(order), 70'(4'b1010));
      mem_ack = 1'b0;
      step();
      step();

      // Reset abandons an LS access and restores IF priority on the next tie.
      if_req = 1'b1; if_addr = 16'h0AAA;
      step();
      check("rst if grant", 70'({mem_req, mem_we, mem_addr}), 70'({1'b1, 1'b0, 16'h0AAA}));
      mem_ack = 1'b1; mem_rdata = 16'h0BBB;
      step();
      check("rst if ack", 70'({if_ack, if_err, if_rdata}), 70'({1'b1, 1'b0, 16'h0BBB}));
      if_req = 1'b0; mem_ack = 1'b0;
      step();
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0555; ls_wdata = 16'h0000;
      step();
      check("rst ls grant", 70'({mem_req, mem_we, mem_addr}), 70'({1'b1, 1'b0, 16'h0555}));
      step();
      check("rst ls wait", 70'({mem_req, ls_ack}), 70'({1'b1, 1'b0}));
      rst = 1'b0; if_req = 1'b1;
      step();
      check("rst abandon", dut_o, 70'(0));
      rst = 1'b1;
      step();
      check("rst regrant", 70'({mem_req, mem_we, mem_addr}), 70'({1'b1, 1'b0, 16'h0AAA}));
      mem_ack = 1'b1; mem_rdata = 16'h0CCC;
      step();
      check("rst if done", 70'({if_ack, if_err, if_rdata, ls_ack}), 70'({1'b1, 1'b0, 16'h0CCC, 1'b0}));
      if_req = 1'b0; ls_req = 1'b0; mem_ack = 1'b0;
      step();
      step();

      // Randomized traffic against the schedule model.
      rst = 1'b0;
      seen = 1'b0;
      age = 0;
      lat = 0;
      for (int c = 0; c < 3000; c++) begin
         step();
         model_step();
         check($sformatf("rnd[%0d]", c), dut_o,
               {m_mreq, m_mwe, m_maddr, m_mwd, m_ifack, m_iferr, m_ifrd, m_lsack, m_lserr, m_lsrd});
         rst = ($urandom_range(0, 299) != 0);
         if (!if_req) begin
            if ($urandom_range(0, 2) == 0) begin
               if_req  = 1'b1;
               if_addr = 16'($urandom);
            end
         end else if (if_ack) begin
            if ($urandom_range(0, 1) == 0) if_req = 1'b0;
            else if_addr = 16'($urandom);
         end
         if (!ls_req) begin
            if ($urandom_range(0, 2) == 0) begin
               ls_req   = 1'b1;
               ls_we    = 1'($urandom);
               ls_addr  = 16'($urandom);
               ls_wdata = 16'($urandom);
            end
         end else if (ls_ack) begin
            if ($urandom_range(0, 1) == 0) begin
               ls_req = 1'b0;
            end else begin
               ls_we    = 1'($urandom);
               ls_addr  = 16'($urandom);
               ls_wdata = 16'($urandom);
            end
         end
         if (mem_req) begin
            if (!seen) begin
               seen = 1'b1;
               age  = 0;
               lat  = $urandom_range(0, 5);
            end
            mem_ack = (age == lat);
            age++;
         end else begin
            seen    = 1'b0;
            mem_ack = ($urandom_range(0, 9) == 0);
         end
         mem_rdata = 16'($urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
